// File: rtl/key_cmd_tx_if.sv
// +----------------------------------------------------------------------+
// | key_cmd_tx_if : controller <-> key/command transmitter signal bundle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface key_cmd_tx_if;
  logic Start;
  logic ModeIn;
  logic Abort;
  logic PeerBusy;
  logic InputKey;
  logic ValidCmd;
  logic TxBusy;
  logic Done;
  logic Error;

  modport master (
    output Start, ModeIn, Abort, PeerBusy,
    input  InputKey, ValidCmd, TxBusy, Done, Error
  );

  modport slave (
    input  Start, ModeIn, Abort, PeerBusy,
    output InputKey, ValidCmd, TxBusy, Done, Error
  );
endinterface

`default_nettype wire

// File: rtl/key_cmd_tx.sv
// +----------------------------------------------------------------------+
// | key_cmd_tx : bit-serial key sender followed by a held mode bit       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_cmd_tx #(
  parameter int               KEY_LEN     = 4,
  parameter logic [KEY_LEN-1:0] KEY_PATTERN = 4'b1010,
  parameter int               GAP_CYCLES  = 2,
  parameter int               HOLD_CYCLES = 2,
  parameter int               TIMEOUT     = 64
) (
  input wire          Clk,
  input wire          Reset,
  key_cmd_tx_if.slave bus
);

  localparam int c_BW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int c_GW = $clog2(GAP_CYCLES) + 1;
  localparam int c_HW = $clog2(HOLD_CYCLES) + 1;
  localparam int c_TW = $clog2(TIMEOUT) + 1;

  localparam logic [c_BW-1:0] c_LAST_IDX = c_BW'(KEY_LEN - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_HW-1:0] c_HOLD     = c_HW'(HOLD_CYCLES);
  localparam logic [c_TW-1:0] c_TO       = c_TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY_BIT   = 3'd1,
    S_GAP       = 3'd2,
    S_MODE_HOLD = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_mode, w_mode_nxt;
  logic [c_BW-1:0] r_bit_idx, w_bit_nxt;
  logic [c_GW-1:0] r_gap_cnt, w_gap_nxt;
  logic [c_HW-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
  logic [c_TW-1:0] r_to_cnt, w_to_nxt, w_to_inc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_hold_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  // bit_idx steps down on the way into the next KEY_BIT, so during GAP it
  // still addresses the bit just sent and InputKey holds it.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_bit_nxt   = r_bit_idx;
    w_gap_nxt   = '0;
    w_hold_nxt  = '0;
    w_to_nxt    = '0;
    w_hold_inc  = bus.PeerBusy ? '0 : r_hold_cnt + 1'b1;
    w_to_inc    = r_to_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (bus.Start && !bus.Abort) begin
          w_mode_nxt  = bus.ModeIn;
          w_bit_nxt   = c_LAST_IDX;
          w_state_nxt = S_KEY_BIT;
        end
      end
      S_KEY_BIT: begin
        if (bus.Abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_bit_idx == '0) begin
          w_state_nxt = S_MODE_HOLD;
        end else if (GAP_CYCLES == 0) begin
          w_bit_nxt = r_bit_idx - 1'b1;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.Abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_bit_nxt   = r_bit_idx - 1'b1;
          w_state_nxt = S_KEY_BIT;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      S_MODE_HOLD: begin
        if (bus.Abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = w_hold_inc;
          w_to_nxt   = w_to_inc;
          if (w_hold_inc == c_HOLD) begin
            w_state_nxt = S_DONE;
          end else if (w_to_inc == c_TO) begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ValidCmd = 1'b0;
    bus.InputKey = 1'b0;
    bus.Done     = 1'b0;
    bus.Error    = 1'b0;
    case (r_state)
      S_KEY_BIT: begin
        bus.ValidCmd = 1'b1;
        bus.InputKey = KEY_PATTERN[r_bit_idx];
      end
      S_GAP:       bus.InputKey = KEY_PATTERN[r_bit_idx];
      S_MODE_HOLD: bus.InputKey = r_mode;
      S_DONE: begin
        bus.Done     = 1'b1;
        bus.InputKey = r_mode;
      end
      S_ERR:   bus.Error = 1'b1;
      default: ;
    endcase
  end

  assign bus.TxBusy = (r_state != S_IDLE);

endmodule

`default_nettype wire
